// File: rtl/instr_type_pkg.sv
// Shared instruction-level types: operand/register widths and decoded instruction kind.
package instr_type;
  localparam int OPERAND_WIDTH             = 32;
  localparam int REGISTER_DESCRIPTOR_WIDTH = 5;

  typedef enum logic [3:0] {
    INSTR_ALU,
    INSTR_LB,
    INSTR_LH,
    INSTR_LW,
    INSTR_LBU,
    INSTR_LHU,
    INSTR_SB,
    INSTR_SH,
    INSTR_SW
  } instr_kind_t;
endpackage

// File: rtl/memory_access_pkg.sv
// Memory-stage parameters: FSM states, bus width, byte-enable patterns, access sizing.
package mem_access_params;
  import instr_type::*;

  localparam int MEM_BUS_WIDTH = 32;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD
  } access_size_t;

  function automatic access_size_t access_size(input instr_kind_t kind);
    case (kind)
      INSTR_LB, INSTR_LBU, INSTR_SB: return SIZE_BYTE;
      INSTR_LH, INSTR_LHU, INSTR_SH: return SIZE_HALF;
      default:                       return SIZE_WORD;
    endcase
  endfunction
endpackage

// File: rtl/memory_access_load_aligner.sv
// load_aligner: picks the byte/halfword at the given lane offset out of a bus word
// and sign- or zero-extends it. kind/offset/rdata in, value out. Purely combinational.
module load_aligner
  import instr_type::*;
  import mem_access_params::*;
(
  input  instr_kind_t               kind,
  input  logic [1:0]                offset,
  input  logic [MEM_BUS_WIDTH-1:0]  rdata,
  output logic [OPERAND_WIDTH-1:0]  value
);

  logic [15:0] lane;

  always_comb begin
    // Lanes above byte 3 shift in as zero, so a halfword at offset 3 keeps only byte 3.
    lane = 16'(rdata >> {offset, 3'b000});
    case (kind)
      INSTR_LB:  value = {{(OPERAND_WIDTH-8){lane[7]}}, lane[7:0]};
      INSTR_LBU: value = {{(OPERAND_WIDTH-8){1'b0}}, lane[7:0]};
      INSTR_LH:  value = {{(OPERAND_WIDTH-16){lane[15]}}, lane};
      INSTR_LHU: value = {{(OPERAND_WIDTH-16){1'b0}}, lane};
      default:   value = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline memory stage. Non-memory results pass with 1-cycle latency;
// loads/stores run one request on the dmem bus (IDLE -> BUS -> RESP) and stall upstream.
// Ports: clk, rst (async, active-low); execution inputs (valid/stall/kind/addresses/data/rd);
// dmem request/response bus; writeback outputs (valid/stall/rd/value) and misaligned_error.
// Optional: MEM_MISALIGNED_CHECK_EN makes misaligned halfword/word accesses skip the bus
// and report misaligned_error instead.
module memory_access
  import instr_type::*;
  import mem_access_params::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 valid_input,
  input  logic                                 stall_input,
  input  instr_kind_t                          instr_kind_input,
  input  logic                                 read_memory,
  input  logic                                 write_memory,
  input  logic [OPERAND_WIDTH-1:0]             read_memory_address,
  input  logic [OPERAND_WIDTH-1:0]             write_memory_address,
  input  logic [OPERAND_WIDTH-1:0]             new_memory_value,
  input  logic                                 write_register,
  input  logic [OPERAND_WIDTH-1:0]             new_register_value,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_input,
  output logic                                 dmem_req,
  output logic                                 dmem_we,
  output logic [MEM_BUS_WIDTH-1:0]             dmem_addr,
  output logic [MEM_BUS_WIDTH-1:0]             dmem_wdata,
  output logic [3:0]                           dmem_be,
  input  logic                                 dmem_ack,
  input  logic [MEM_BUS_WIDTH-1:0]             dmem_rdata,
  output logic                                 valid_output,
  output logic                                 stall_output,
  output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_addr_output,
  output logic                                 write_register_output,
  output logic [OPERAND_WIDTH-1:0]             new_register_value_output,
  output logic                                 misaligned_error
);

  state_t                   state, state_next;
  logic                     is_mem, accept, misaligned;
  logic [OPERAND_WIDTH-1:0] mem_addr;
  logic [1:0]               offset;
  access_size_t             size;
  logic [3:0]               be_calc;
  logic [MEM_BUS_WIDTH-1:0] wdata_calc;

  instr_kind_t              kind_q;
  logic [1:0]               offset_q;
  logic [MEM_BUS_WIDTH-1:0] addr_q, wdata_q;
  logic                     we_q;
  logic [3:0]               be_q;

  logic                                 valid_q, wr_q, mis_q;
  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] rd_q;
  logic [OPERAND_WIDTH-1:0]             value_q;
  logic [OPERAND_WIDTH-1:0]             load_value;

  assign is_mem   = read_memory | write_memory;
  assign accept   = (state == ST_IDLE) & valid_input & ~stall_input;
  // A store takes priority when both request flags are set.
  assign mem_addr = write_memory ? write_memory_address : read_memory_address;
  assign offset   = mem_addr[1:0];
  assign size     = access_size(instr_kind_input);

`ifdef MEM_MISALIGNED_CHECK_EN
  assign misaligned = is_mem &
                      (((size == SIZE_HALF) & offset[0]) | ((size == SIZE_WORD) & (offset != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    be_calc    = BE_WORD;
    wdata_calc = new_memory_value;
    case (size)
      SIZE_BYTE: begin
        be_calc    = BE_BYTE << offset;
        wdata_calc = {4{new_memory_value[7:0]}};
      end
      SIZE_HALF: begin
        be_calc    = BE_HALF << offset;
        wdata_calc = {2{new_memory_value[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next   = state;
    dmem_req     = 1'b0;
    stall_output = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_output = stall_input | (valid_input & is_mem);
        if (accept && is_mem) state_next = misaligned ? ST_RESP : ST_BUS;
      end
      ST_BUS: begin
        dmem_req     = 1'b1;
        stall_output = 1'b1;
        if (dmem_ack) state_next = ST_RESP;
      end
      ST_RESP: begin
        stall_output = 1'b1;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!rst) stall_output = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind_q   <= INSTR_ALU;
      offset_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      valid_q  <= 1'b0;
      wr_q     <= 1'b0;
      mis_q    <= 1'b0;
      rd_q     <= '0;
      value_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      if (accept) begin
        rd_q <= rd_addr_input;
        if (!is_mem) begin
          valid_q <= 1'b1;
          wr_q    <= write_register;
          value_q <= new_register_value;
        end else begin
          kind_q   <= instr_kind_input;
          offset_q <= offset;
          addr_q   <= {mem_addr[MEM_BUS_WIDTH-1:2], 2'b00};
          wdata_q  <= wdata_calc;
          we_q     <= write_memory;
          be_q     <= be_calc;
          wr_q     <= ~write_memory & ~misaligned;
          value_q  <= '0;
          if (misaligned) begin
            valid_q <= 1'b1;
            mis_q   <= 1'b1;
          end
        end
      end else if ((state == ST_BUS) && dmem_ack) begin
        valid_q <= 1'b1;
        if (!we_q) value_q <= load_value;
      end
    end
  end

  load_aligner u_load_aligner (
    .kind   (kind_q),
    .offset (offset_q),
    .rdata  (dmem_rdata),
    .value  (load_value)
  );

  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = dmem_req ? addr_q  : '0;
  assign dmem_wdata = dmem_req ? wdata_q : '0;
  assign dmem_be    = dmem_req ? be_q    : '0;

  assign valid_output              = valid_q;
  assign rd_addr_output            = rd_q;
  assign write_register_output     = wr_q;
  assign new_register_value_output = value_q;
  assign misaligned_error          = mis_q;

endmodule

// File: tb/tb_memory_access.sv
`timescale 1ns/1ps
module tb_memory_access;
  import instr_type::*;
  import mem_access_params::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid_input, stall_input;
  instr_kind_t instr_kind_input;
  logic        read_memory, write_memory;
  logic [31:0] read_memory_address, write_memory_address, new_memory_value;
  logic        write_register;
  logic [31:0] new_register_value;
  logic [4:0]  rd_addr_input;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        valid_output, stall_output;
  logic [4:0]  rd_addr_output;
  logic        write_register_output;
  logic [31:0] new_register_value_output;
  logic        misaligned_error;

  int errors = 0;
  int checks = 0;

  // Observations gathered by run_txn
  logic        o_accept_stall, o_stall_low, o_unstable, o_timeout;
  int          o_valid_cnt, o_req_cnt, o_latency;
  logic [31:0] o_value, o_addr, o_wdata;
  logic        o_wr, o_we, o_mis;
  logic [4:0]  o_rd;
  logic [3:0]  o_be;

  memory_access dut (
    .clk                       (clk),
    .rst                       (rst),
    .valid_input               (valid_input),
    .stall_input               (stall_input),
    .instr_kind_input          (instr_kind_input),
    .read_memory               (read_memory),
    .write_memory              (write_memory),
    .read_memory_address       (read_memory_address),
    .write_memory_address      (write_memory_address),
    .new_memory_value          (new_memory_value),
    .write_register            (write_register),
    .new_register_value        (new_register_value),
    .rd_addr_input             (rd_addr_input),
    .dmem_req                  (dmem_req),
    .dmem_we                   (dmem_we),
    .dmem_addr                 (dmem_addr),
    .dmem_wdata                (dmem_wdata),
    .dmem_be                   (dmem_be),
    .dmem_ack                  (dmem_ack),
    .dmem_rdata                (dmem_rdata),
    .valid_output              (valid_output),
    .stall_output              (stall_output),
    .rd_addr_output            (rd_addr_output),
    .write_register_output     (write_register_output),
    .new_register_value_output (new_register_value_output),
    .misaligned_error          (misaligned_error)
  );

  // ---------------- reference model ----------------
  function automatic int m_bytes(input instr_kind_t k);
    if (k == INSTR_LB || k == INSTR_LBU || k == INSTR_SB) return 1;
    if (k == INSTR_LH || k == INSTR_LHU || k == INSTR_SH) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_load(input instr_kind_t k, input int off, input logic [31:0] rdata);
    int unsigned lanes, b, h;
    lanes = rdata >> (8 * off);
    b = lanes % 256;
    h = lanes % 65536;
    case (k)
      INSTR_LB:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      INSTR_LBU: return b;
      INSTR_LH:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      INSTR_LHU: return h;
      default:   return rdata;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input instr_kind_t k, input int off);
    int unsigned n;
    n = m_bytes(k);
    if (n == 1) return 4'((1 << off) % 16);
    if (n == 2) return 4'((3 << off) % 16);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input instr_kind_t k, input logic [31:0] d);
    int unsigned n;
    n = m_bytes(k);
    if (n == 1) return (d % 256) * 32'h0101_0101;
    if (n == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit m_mis(input instr_kind_t k, input int off);
`ifdef MEM_MISALIGNED_CHECK_EN
    return (m_bytes(k) == 2 && (off % 2) != 0) || (m_bytes(k) == 4 && off != 0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- stimulus driver / observer ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input instr_kind_t k, input logic rm, input logic wm,
                         input logic [31:0] raddr, input logic [31:0] waddr,
                         input logic [31:0] data, input logic [4:0] rd, input logic wreg,
                         input logic [31:0] nrv, input logic [31:0] rdata, input int waits);
    valid_input = 1'b1; stall_input = 1'b0; instr_kind_input = k;
    read_memory = rm; write_memory = wm;
    read_memory_address = raddr; write_memory_address = waddr;
    new_memory_value = data; rd_addr_input = rd; write_register = wreg; new_register_value = nrv;
    #1;
    o_accept_stall = stall_output;
    o_valid_cnt = 0; o_req_cnt = 0; o_latency = 0;
    o_stall_low = 1'b0; o_unstable = 1'b0; o_timeout = 1'b1;
    tick();
    valid_input = 1'b0;
    for (int c = 1; c < 80; c++) begin
      if (o_valid_cnt > 0 && !valid_output) begin
        o_timeout = 1'b0;
        break;
      end
      if (o_valid_cnt == 0 && !stall_output) o_stall_low = 1'b1;
      if (valid_output) begin
        if (o_valid_cnt == 0) begin
          o_latency = c + 1;
          o_value = new_register_value_output; o_wr = write_register_output;
          o_rd = rd_addr_output; o_mis = misaligned_error;
        end
        o_valid_cnt++;
      end
      if (dmem_req) begin
        if (o_req_cnt == 0) begin
          o_addr = dmem_addr; o_we = dmem_we; o_be = dmem_be; o_wdata = dmem_wdata;
        end else if (dmem_addr !== o_addr || dmem_we !== o_we || dmem_be !== o_be || dmem_wdata !== o_wdata) begin
          o_unstable = 1'b1;
        end
        o_req_cnt++;
        if (o_req_cnt > waits) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
      end
      tick();
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    valid_input = 1'b1; stall_input = 1'b1; read_memory = 1'b1; dmem_ack = 1'b1;
    #12;
    checks++; if (stall_output !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_output); end
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
    checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_output); end
    checks++; if (misaligned_error !== 1'b0) begin errors++; $display("FAIL reset_mis got=%b exp=0", misaligned_error); end
    checks++; if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== '0) begin errors++; $display("FAIL reset_bus got=%h exp=0", {dmem_we, dmem_be, dmem_addr, dmem_wdata}); end
    checks++; if ({write_register_output, rd_addr_output, new_register_value_output} !== '0) begin errors++; $display("FAIL reset_wb got=%h exp=0", {write_register_output, rd_addr_output, new_register_value_output}); end
    tick();
    valid_input = 1'b0; stall_input = 1'b0; read_memory = 1'b0; dmem_ack = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    run_txn(INSTR_ALU, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0000_0005, 32'h0, 0);
    checks++; if (o_timeout) begin errors++; $display("FAIL addi_timeout got=timeout exp=valid"); end
    checks++; if (o_latency !== 2) begin errors++; $display("FAIL addi_latency got=%0d exp=2", o_latency); end
    checks++; if (o_rd !== 5'd3 || o_value !== 32'h5 || o_wr !== 1'b1) begin errors++; $display("FAIL addi_result got=rd%0d/%h/%b exp=rd3/00000005/1", o_rd, o_value, o_wr); end
    checks++; if (o_req_cnt !== 0) begin errors++; $display("FAIL addi_no_req got=%0d exp=0", o_req_cnt); end
  endtask

  task automatic test_lb_wait();
    run_txn(INSTR_LB, 1'b1, 1'b0, 32'h1003, 32'h7777, 32'h0, 5'd9, 1'b1, 32'h0, 32'h8000_0000, 2);
    checks++; if (o_timeout) begin errors++; $display("FAIL lb_timeout got=timeout exp=valid"); end
    checks++; if (o_addr !== 32'h1000) begin errors++; $display("FAIL lb_addr got=%h exp=00001000", o_addr); end
    checks++; if (o_value !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_value got=%h exp=ffffff80", o_value); end
    checks++; if (o_valid_cnt !== 1) begin errors++; $display("FAIL lb_valid_cycles got=%0d exp=1", o_valid_cnt); end
    checks++; if (o_accept_stall !== 1'b1 || o_stall_low !== 1'b0) begin errors++; $display("FAIL lb_stall got=acc%b/low%b exp=acc1/low0", o_accept_stall, o_stall_low); end
    checks++; if (o_latency !== 5 || o_req_cnt !== 3) begin errors++; $display("FAIL lb_timing got=lat%0d/req%0d exp=lat5/req3", o_latency, o_req_cnt); end
    checks++; if (o_wr !== 1'b1 || o_rd !== 5'd9) begin errors++; $display("FAIL lb_wb got=%b/rd%0d exp=1/rd9", o_wr, o_rd); end
  endtask

  task automatic test_sh_store();
    run_txn(INSTR_SH, 1'b0, 1'b1, 32'h5555, 32'h2002, 32'h0000_BEEF, 5'd4, 1'b1, 32'h0, 32'h0, 1);
    checks++; if (o_timeout) begin errors++; $display("FAIL sh_timeout got=timeout exp=valid"); end
    checks++; if (o_we !== 1'b1 || o_addr !== 32'h2000) begin errors++; $display("FAIL sh_req got=we%b/%h exp=we1/00002000", o_we, o_addr); end
    checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL sh_be got=%b exp=1100", o_be); end
    checks++; if (o_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got=%h exp=beefbeef", o_wdata); end
    checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL sh_wr got=%b exp=0", o_wr); end
    checks++; if (o_unstable !== 1'b0) begin errors++; $display("FAIL sh_stable got=%b exp=0", o_unstable); end
  endtask

  task automatic test_lhu_lh();
    run_txn(INSTR_LHU, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0, 32'h1234_8765, 0);
    checks++; if (o_value !== 32'h0000_8765 || o_timeout) begin errors++; $display("FAIL lhu_value got=%h exp=00008765", o_value); end
    checks++; if (o_latency !== 3) begin errors++; $display("FAIL lhu_latency got=%0d exp=3", o_latency); end
    run_txn(INSTR_LH, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0, 32'h1234_8765, 0);
    checks++; if (o_value !== 32'hFFFF_8765 || o_timeout) begin errors++; $display("FAIL lh_value got=%h exp=ffff8765", o_value); end
  endtask

  task automatic test_both_flags();
    run_txn(INSTR_SW, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0604, 32'hCAFE_F00D, 5'd6, 1'b1, 32'h0, 32'hFFFF_FFFF, 0);
    checks++; if (o_we !== 1'b1 || o_addr !== 32'h604) begin errors++; $display("FAIL both_store got=we%b/%h exp=we1/00000604", o_we, o_addr); end
    checks++; if (o_wr !== 1'b0 || o_timeout) begin errors++; $display("FAIL both_wr got=%b exp=0", o_wr); end
  endtask

  task automatic test_misaligned();
    run_txn(INSTR_LW, 1'b1, 1'b0, 32'h3001, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0, 32'hA5A5_5A5A, 0);
    checks++; if (o_timeout) begin errors++; $display("FAIL mis_timeout got=timeout exp=valid"); end
`ifdef MEM_MISALIGNED_CHECK_EN
    checks++; if (o_mis !== 1'b1) begin errors++; $display("FAIL mis_flag got=%b exp=1", o_mis); end
    checks++; if (o_req_cnt !== 0) begin errors++; $display("FAIL mis_no_req got=%0d exp=0", o_req_cnt); end
    checks++; if (o_wr !== 1'b0) begin errors++; $display("FAIL mis_wr got=%b exp=0", o_wr); end
`else
    checks++; if (o_addr !== 32'h3000) begin errors++; $display("FAIL mis_addr got=%h exp=00003000", o_addr); end
    checks++; if (o_mis !== 1'b0) begin errors++; $display("FAIL mis_flag got=%b exp=0", o_mis); end
    checks++; if (o_value !== 32'hA5A5_5A5A) begin errors++; $display("FAIL mis_value got=%h exp=a5a55a5a", o_value); end
`endif
  endtask

  task automatic test_stall_input();
    int bad;
    bad = 0;
    valid_input = 1'b1; stall_input = 1'b1; instr_kind_input = INSTR_ALU;
    read_memory = 1'b0; write_memory = 1'b0;
    rd_addr_input = 5'd7; write_register = 1'b1; new_register_value = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (valid_output !== 1'b0 || stall_output !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
    stall_input = 1'b0;
    #1;
    checks++; if (stall_output !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", stall_output); end
    tick();
    valid_input = 1'b0;
    checks++; if (valid_output !== 1'b1 || new_register_value_output !== 32'h1234 || rd_addr_output !== 5'd7) begin errors++; $display("FAIL stall_accept got=%b/%h/rd%0d exp=1/00001234/rd7", valid_output, new_register_value_output, rd_addr_output); end
    tick();
    checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL stall_single got=%b exp=0", valid_output); end
  endtask

  task automatic test_spurious_ack();
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_ack = 1'b1; dmem_rdata = $urandom;
      tick();
      if (valid_output !== 1'b0 || dmem_req !== 1'b0) bad++;
    end
    dmem_ack = 1'b0;
    tick();
    if (valid_output !== 1'b0) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_ack got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    valid_input = 1'b1; stall_input = 1'b0; instr_kind_input = INSTR_LW;
    read_memory = 1'b1; write_memory = 1'b0; read_memory_address = 32'h4000; rd_addr_input = 5'd8;
    tick();
    valid_input = 1'b0;
    tick();
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstmid_bus got=%b exp=1", dmem_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || stall_output !== 1'b0 || valid_output !== 1'b0) begin errors++; $display("FAIL rstmid_clear got=req%b/stall%b/valid%b exp=000", dmem_req, stall_output, valid_output); end
    tick();
    rst = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    dmem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (valid_output !== 1'b0 || dmem_req !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_no_result got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_random_mix();
    instr_kind_t lk[5];
    instr_kind_t sk[3];
    instr_kind_t k;
    int          cat, waits, off, exp_lat, exp_req;
    logic [31:0] raddr, waddr, data, nrv, rdata, exp_addr, exp_val;
    logic [4:0]  rd;
    logic        wreg, rm, wm, exp_wr;
    bit          mis;
    lk = '{INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};
    sk = '{INSTR_SB, INSTR_SH, INSTR_SW};
    for (int i = 0; i < 60; i++) begin
      cat = int'($urandom_range(2, 0));
      raddr = $urandom; waddr = $urandom; data = $urandom; nrv = $urandom; rdata = $urandom;
      rd = 5'($urandom); wreg = 1'($urandom); waits = int'($urandom_range(3, 0));
      if (cat == 0) begin
        k = INSTR_ALU; rm = 1'b0; wm = 1'b0;
      end else if (cat == 1) begin
        k = lk[$urandom_range(4, 0)]; rm = 1'b1; wm = 1'b0;
      end else begin
        k = sk[$urandom_range(2, 0)]; rm = 1'($urandom); wm = 1'b1;
      end
      exp_addr = (cat == 2) ? waddr : raddr;
      off = int'(exp_addr % 4);
      exp_addr = exp_addr - off;
      mis = (cat != 0) && m_mis(k, off);
      exp_lat = (cat == 0 || mis) ? 2 : waits + 3;
      exp_req = (cat == 0 || mis) ? 0 : waits + 1;
      exp_wr  = (cat == 0) ? wreg : (cat == 1 && !mis);
      exp_val = (cat == 0) ? nrv : m_load(k, off, rdata);
      run_txn(k, rm, wm, raddr, waddr, data, rd, wreg, nrv, rdata, waits);
      checks++; if (o_timeout || o_valid_cnt != 1) begin errors++; $display("FAIL rnd%0d_valid got=cnt%0d/to%b exp=cnt1/to0", i, o_valid_cnt, o_timeout); end
      checks++; if (o_latency != exp_lat || o_req_cnt != exp_req) begin errors++; $display("FAIL rnd%0d_timing got=lat%0d/req%0d exp=lat%0d/req%0d", i, o_latency, o_req_cnt, exp_lat, exp_req); end
      checks++; if (o_wr !== exp_wr || o_mis !== logic'(mis)) begin errors++; $display("FAIL rnd%0d_flags got=wr%b/mis%b exp=wr%b/mis%b", i, o_wr, o_mis, exp_wr, mis); end
      if (exp_wr) begin
        checks++; if (o_rd !== rd || o_value !== exp_val) begin errors++; $display("FAIL rnd%0d_result got=rd%0d/%h exp=rd%0d/%h", i, o_rd, o_value, rd, exp_val); end
      end
      if (cat != 0) begin
        checks++; if (o_accept_stall !== 1'b1 || o_stall_low !== 1'b0) begin errors++; $display("FAIL rnd%0d_stall got=acc%b/low%b exp=acc1/low0", i, o_accept_stall, o_stall_low); end
      end
      if (exp_req > 0) begin
        checks++; if (o_addr !== exp_addr || o_we !== (cat == 2) || o_unstable !== 1'b0) begin errors++; $display("FAIL rnd%0d_bus got=%h/we%b/unst%b exp=%h/we%b/unst0", i, o_addr, o_we, o_unstable, exp_addr, cat == 2); end
        if (cat == 2) begin
          checks++; if (o_be !== m_be(k, off) || o_wdata !== m_wdata(k, data)) begin errors++; $display("FAIL rnd%0d_lanes got=%b/%h exp=%b/%h", i, o_be, o_wdata, m_be(k, off), m_wdata(k, data)); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    valid_input = 1'b0; stall_input = 1'b0; instr_kind_input = INSTR_ALU;
    read_memory = 1'b0; write_memory = 1'b0;
    read_memory_address = '0; write_memory_address = '0; new_memory_value = '0;
    write_register = 1'b0; new_register_value = '0; rd_addr_input = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    test_reset();
    test_addi();
    test_lb_wait();
    test_sh_store();
    test_lhu_lh();
    test_both_flags();
    test_misaligned();
    test_stall_input();
    test_spurious_ack();
    test_reset_mid();
    test_random_mix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
